// File: rtl/qspi_flash_sequencer_if.sv
// Signal bundle between a flash requester, the command sequencer and the qspi_fsm engine.
// The slave modport is the sequencer; the master modport is the requester plus qspi_fsm side.
interface qspi_flash_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_len;
    logic        resp_valid;
    logic        resp_err;
    logic [15:0] resp_polls;
    logic        busy;
    logic        fsm_start;
    logic        fsm_done;
    logic [7:0]  fsm_cmd_opcode;
    logic [31:0] fsm_addr;
    logic [1:0]  fsm_addr_bytes_sel;
    logic [31:0] fsm_len_bytes;
    logic        fsm_dir;
    logic [3:0]  fsm_dummy_cycles;
    logic [31:0] fsm_rx_data;
    logic        fsm_rx_wen;

    modport slave (
        input  req_valid, req_op, req_addr, req_len, fsm_done, fsm_rx_data, fsm_rx_wen,
        output req_ready, resp_valid, resp_err, resp_polls, busy, fsm_start,
               fsm_cmd_opcode, fsm_addr, fsm_addr_bytes_sel, fsm_len_bytes, fsm_dir, fsm_dummy_cycles
    );

    modport master (
        output req_valid, req_op, req_addr, req_len, fsm_done, fsm_rx_data, fsm_rx_wen,
        input  req_ready, resp_valid, resp_err, resp_polls, busy, fsm_start,
               fsm_cmd_opcode, fsm_addr, fsm_addr_bytes_sel, fsm_len_bytes, fsm_dir, fsm_dummy_cycles
    );
endinterface

// File: rtl/qspi_flash_sequencer.sv
// Flash command sequencer: expands one request into WREN, the operation, then RDSR polls
// until write-in-progress clears or the poll limit is reached, and reports one response.
module qspi_flash_sequencer #(
    parameter logic [15:0] POLL_LIMIT = 16'd1000,
    parameter logic [7:0]  POLL_GAP   = 8'd4,
    parameter int unsigned WIP_BIT    = 0
) (
    input logic                   clk,
    input logic                   rst,
    qspi_flash_sequencer_if.slave bus
);
    localparam logic [2:0] WIP_IDX = 3'(WIP_BIT);

    typedef enum logic [3:0] {
        IDLE, WREN_GO, WREN_WAIT, OP_GO, OP_WAIT, GAP, POLL_GO, POLL_WAIT, CHECK, RESP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] len_q;
    logic [15:0] poll_cnt;
    logic [7:0]  gap_cnt;
    logic [7:0]  status_q;
    logic        err_q;
    logic [7:0]  opcode_q;
    logic [31:0] cfg_addr_q;
    logic [1:0]  cfg_sel_q;
    logic [31:0] cfg_len_q;
    logic        cfg_dir_q;
    logic        accept;
    logic        gap_done;
    logic        wip;
    logic        unused_rx_hi;

    assign accept       = (state == IDLE) && bus.req_valid;
    // A zero gap still spends one cycle in GAP
    assign gap_done     = ({1'b0, gap_cnt} + 9'd1) >= {1'b0, POLL_GAP};
    assign wip          = status_q[WIP_IDX];
    assign unused_rx_hi = ^bus.fsm_rx_data[31:8];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (bus.req_valid) state_next = WREN_GO;
            WREN_GO:   state_next = WREN_WAIT;
            WREN_WAIT: if (bus.fsm_done) state_next = OP_GO;
            OP_GO:     state_next = OP_WAIT;
            OP_WAIT:   if (bus.fsm_done) state_next = GAP;
            GAP:       if (gap_done) state_next = POLL_GO;
            POLL_GO:   state_next = POLL_WAIT;
            POLL_WAIT: if (bus.fsm_done) state_next = CHECK;
            CHECK: begin
                if (!wip || (poll_cnt == POLL_LIMIT)) begin
                    state_next = RESP;
                end else begin
                    state_next = GAP;
                end
            end
            RESP:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= 2'd0;
            addr_q     <= 32'd0;
            len_q      <= 32'd0;
            poll_cnt   <= 16'd0;
            gap_cnt    <= 8'd0;
            status_q   <= 8'd0;
            err_q      <= 1'b0;
            opcode_q   <= 8'd0;
            cfg_addr_q <= 32'd0;
            cfg_sel_q  <= 2'd0;
            cfg_len_q  <= 32'd0;
            cfg_dir_q  <= 1'b0;
        end else begin
            if (accept) begin
                op_q     <= bus.req_op;
                addr_q   <= bus.req_addr;
                len_q    <= bus.req_len;
                poll_cnt <= 16'd0;
                err_q    <= 1'b0;
            end
            gap_cnt <= (state == GAP) ? gap_cnt + 8'd1 : 8'd0;
            // Preset to busy so a poll that never delivers a status byte is retried
            if (state == POLL_GO) begin
                status_q <= 8'hFF;
                if (poll_cnt != 16'hFFFF) poll_cnt <= poll_cnt + 16'd1;
            end else if ((state == POLL_WAIT) && bus.fsm_rx_wen) begin
                status_q <= bus.fsm_rx_data[7:0];
            end
            if (state == CHECK) err_q <= wip;
            // Transaction config is loaded on entry to a GO state and held through its WAIT
            case (state_next)
                WREN_GO: begin
                    opcode_q   <= 8'h06;
                    cfg_addr_q <= 32'd0;
                    cfg_sel_q  <= 2'b00;
                    cfg_len_q  <= 32'd0;
                    cfg_dir_q  <= 1'b0;
                end
                OP_GO: begin
                    cfg_dir_q <= 1'b0;
                    case (op_q)
                        2'b00: begin
                            opcode_q   <= 8'h02;
                            cfg_addr_q <= addr_q;
                            cfg_sel_q  <= 2'b01;
                            cfg_len_q  <= len_q;
                        end
                        2'b01: begin
                            opcode_q   <= 8'h20;
                            cfg_addr_q <= addr_q;
                            cfg_sel_q  <= 2'b01;
                            cfg_len_q  <= 32'd0;
                        end
                        2'b10: begin
                            opcode_q   <= 8'hC7;
                            cfg_addr_q <= 32'd0;
                            cfg_sel_q  <= 2'b00;
                            cfg_len_q  <= 32'd0;
                        end
                        default: begin
                            opcode_q   <= 8'h01;
                            cfg_addr_q <= 32'd0;
                            cfg_sel_q  <= 2'b00;
                            cfg_len_q  <= len_q;
                        end
                    endcase
                end
                POLL_GO: begin
                    opcode_q   <= 8'h05;
                    cfg_addr_q <= 32'd0;
                    cfg_sel_q  <= 2'b00;
                    cfg_len_q  <= 32'd1;
                    cfg_dir_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.req_ready  = (state == IDLE);
        bus.busy       = (state != IDLE);
        bus.fsm_start  = (state == WREN_GO) || (state == OP_GO) || (state == POLL_GO);
        bus.resp_valid = (state == RESP);
        bus.resp_err   = (state == RESP) && err_q;
        bus.resp_polls = (state == RESP) ? poll_cnt : 16'd0;
    end

    assign bus.fsm_cmd_opcode     = opcode_q;
    assign bus.fsm_addr           = cfg_addr_q;
    assign bus.fsm_addr_bytes_sel = cfg_sel_q;
    assign bus.fsm_len_bytes      = cfg_len_q;
    assign bus.fsm_dir            = cfg_dir_q;
    assign bus.fsm_dummy_cycles   = 4'd0;
endmodule

// File: tb/tb_qspi_flash_sequencer.sv
// Bench for qspi_flash_sequencer: a scripted qspi_fsm responder plus a request-level model
// that predicts the transaction list and the response from the status bytes returned.
module tb_qspi_flash_sequencer;
    localparam logic [15:0] TB_POLL_LIMIT = 16'd4;
    localparam logic [7:0]  TB_POLL_GAP   = 8'd4;
    localparam int          TB_WIP_BIT    = 0;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [31:0] addr;
        logic [1:0]  sel;
        logic [31:0] len;
        logic        dir;
        logic [3:0]  dummy;
    } cfg_t;

    typedef struct {
        cfg_t at_start;
        cfg_t at_done;
        int   start;
        int   done;
    } txn_t;

    logic clk = 1'b0;
    logic rst;
    int   cycle = 0;
    int   checks = 0;
    int   errors = 0;
    int   start_count = 0;
    int   resp_count = 0;
    bit   stall = 1'b0;
    logic [7:0] stall_op = 8'h00;
    int   script[$];
    txn_t txn_log[$];
    cfg_t exp_q[$];
    logic exp_err;
    int   exp_polls;

    qspi_flash_sequencer_if bus();

    qspi_flash_sequencer #(
        .POLL_LIMIT(TB_POLL_LIMIT),
        .POLL_GAP  (TB_POLL_GAP),
        .WIP_BIT   (TB_WIP_BIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (bus.fsm_start === 1'b1) start_count <= start_count + 1;
        if (bus.resp_valid === 1'b1) resp_count <= resp_count + 1;
    end

    function automatic cfg_t read_cfg();
        cfg_t c;
        c.opcode = bus.fsm_cmd_opcode;
        c.addr   = bus.fsm_addr;
        c.sel    = bus.fsm_addr_bytes_sel;
        c.len    = bus.fsm_len_bytes;
        c.dir    = bus.fsm_dir;
        c.dummy  = bus.fsm_dummy_cycles;
        return c;
    endfunction

    function automatic cfg_t mk(input logic [7:0] o, input logic [31:0] a, input logic [1:0] s,
                                input logic [31:0] l, input logic d);
        cfg_t c;
        c.opcode = o;
        c.addr   = a;
        c.sel    = s;
        c.len    = l;
        c.dir    = d;
        c.dummy  = 4'd0;
        return c;
    endfunction

    // Request-level model; a negative script entry means the poll delivers no status byte
    task automatic build_model(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] len,
                               input int scr[$]);
        int st;
        bit wip;
        exp_q.delete();
        exp_q.push_back(mk(8'h06, 32'd0, 2'b00, 32'd0, 1'b0));
        case (op)
            2'b00:   exp_q.push_back(mk(8'h02, addr, 2'b01, len, 1'b0));
            2'b01:   exp_q.push_back(mk(8'h20, addr, 2'b01, 32'd0, 1'b0));
            2'b10:   exp_q.push_back(mk(8'hC7, 32'd0, 2'b00, 32'd0, 1'b0));
            default: exp_q.push_back(mk(8'h01, 32'd0, 2'b00, len, 1'b0));
        endcase
        exp_err   = 1'b0;
        exp_polls = 0;
        for (int k = 1; k <= 65535; k++) begin
            exp_q.push_back(mk(8'h05, 32'd0, 2'b00, 32'd1, 1'b1));
            st  = (k <= scr.size()) ? scr[k-1] : -1;
            wip = (st < 0) ? 1'b1 : st[TB_WIP_BIT];
            exp_polls = k;
            if (!wip) break;
            if (k == int'(TB_POLL_LIMIT)) begin
                exp_err = 1'b1;
                break;
            end
        end
    endtask

    initial begin : responder
        txn_t t;
        int   lat;
        int   st;
        int   guard;
        bus.fsm_done    = 1'b0;
        bus.fsm_rx_wen  = 1'b0;
        bus.fsm_rx_data = 32'd0;
        forever begin
            @(negedge clk);
            bus.fsm_done   = 1'b0;
            bus.fsm_rx_wen = 1'b0;
            if (bus.fsm_start === 1'b1) begin
                t.at_start = read_cfg();
                t.start    = cycle;
                lat = $urandom_range(1, 3);
                repeat (lat) @(negedge clk);
                guard = 0;
                while (stall && (t.at_start.opcode == stall_op) && guard < 1000) begin
                    @(negedge clk);
                    guard++;
                end
                if (t.at_start.opcode == 8'h05) begin
                    st = (script.size() > 0) ? script.pop_front() : -1;
                    if (st >= 0) begin
                        bus.fsm_rx_data      = $urandom();
                        bus.fsm_rx_data[7:0] = st[7:0];
                        bus.fsm_rx_wen       = 1'b1;
                        if ($urandom_range(0, 1) == 1) begin
                            @(negedge clk);
                            bus.fsm_rx_wen = 1'b0;
                        end
                    end
                end
                t.at_done    = read_cfg();
                t.done       = cycle;
                bus.fsm_done = 1'b1;
                txn_log.push_back(t);
            end
        end
    end

    task automatic send_req(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] len,
                            output int acc_cycle);
        int guard;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_len   = len;
        guard = 0;
        while (bus.req_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            errors++;
            $display("[TB] FAIL accept_wait: req_ready got %b after 200 cycles, required 1", bus.req_ready);
        end
        acc_cycle = cycle;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp(output logic r_err, output logic [15:0] r_polls, output int r_cycle);
        int guard;
        guard   = 0;
        r_err   = 1'bx;
        r_polls = 16'hxxxx;
        r_cycle = -1;
        while (bus.resp_valid !== 1'b1 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (bus.resp_valid === 1'b1) begin
            r_err   = bus.resp_err;
            r_polls = bus.resp_polls;
            r_cycle = cycle;
        end else begin
            errors++;
            $display("[TB] FAIL resp_wait: resp_valid got %b after 3000 cycles, required 1", bus.resp_valid);
        end
    endtask

    task automatic test_reset();
        int acc;
        int guard;
        int starts_before;
        int resp_before;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.fsm_start, bus.resp_valid, bus.req_ready} !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL reset_hold: busy/start/resp/ready got %b, required 0001",
                     {bus.busy, bus.fsm_start, bus.resp_valid, bus.req_ready});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: ready=%b busy=%b, required ready=1 busy=0", bus.req_ready, bus.busy);
        end
        checks++;
        if (read_cfg() !== cfg_t'(0) || bus.resp_polls !== 16'd0 || bus.resp_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: cfg=%h polls=%h err=%b, required all zero",
                     read_cfg(), bus.resp_polls, bus.resp_err);
        end

        stall    = 1'b1;
        stall_op = 8'h20;
        script.delete();
        send_req(2'b01, 32'h0001_2000, 32'd0, acc);
        guard = 0;
        while (!(bus.fsm_start === 1'b1 && bus.fsm_cmd_opcode === 8'h20) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            errors++;
            $display("[TB] FAIL reset_op_wait: no erase start seen, opcode got %h required 20", bus.fsm_cmd_opcode);
        end
        repeat (2) @(negedge clk);
        starts_before = start_count;
        resp_before   = resp_count;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.fsm_start, bus.resp_valid} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_mid_op: busy/start/resp got %b, required 000",
                     {bus.busy, bus.fsm_start, bus.resp_valid});
        end
        rst   = 1'b0;
        stall = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_after: ready=%b busy=%b, required ready=1 busy=0", bus.req_ready, bus.busy);
        end
        checks++;
        if (resp_count !== resp_before || start_count !== starts_before) begin
            errors++;
            $display("[TB] FAIL reset_abandon: resp delta %0d start delta %0d, required 0 and 0",
                     resp_count - resp_before, start_count - starts_before);
        end
        checks++;
        if (bus.fsm_cmd_opcode !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_cfg_clear: opcode got %h, required 00", bus.fsm_cmd_opcode);
        end
        txn_log.delete();
    endtask

    task automatic test_sector_erase();
        int s[$];
        int acc;
        int rc;
        logic r_err;
        logic [15:0] r_polls;
        s = '{8'h03, 8'h03, 8'h00};
        build_model(2'b01, 32'h0001_2000, 32'h0000_0055, s);
        script = s;
        txn_log.delete();
        send_req(2'b01, 32'h0001_2000, 32'h0000_0055, acc);
        wait_resp(r_err, r_polls, rc);
        checks++;
        if (txn_log.size() !== exp_q.size()) begin
            errors++;
            $display("[TB] FAIL erase_txn_count: got %0d, required %0d", txn_log.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < txn_log.size(); i++) begin
            checks++;
            if (txn_log[i].at_start !== exp_q[i] || txn_log[i].at_done !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL erase_txn%0d: got start %h done %h, required %h",
                         i, txn_log[i].at_start, txn_log[i].at_done, exp_q[i]);
            end
        end
        checks++;
        if (r_err !== exp_err || r_polls !== 16'(exp_polls)) begin
            errors++;
            $display("[TB] FAIL erase_resp: got err=%b polls=%0d, required err=%b polls=%0d",
                     r_err, r_polls, exp_err, exp_polls);
        end
    endtask

    task automatic test_program();
        int s[$];
        int acc;
        int rc;
        logic r_err;
        logic [15:0] r_polls;
        logic [31:0] addr;
        addr = {8'h00, 24'($urandom())};
        s = '{8'h00};
        build_model(2'b00, addr, 32'd256, s);
        script = s;
        txn_log.delete();
        send_req(2'b00, addr, 32'd256, acc);
        wait_resp(r_err, r_polls, rc);
        checks++;
        if (txn_log.size() !== exp_q.size()) begin
            errors++;
            $display("[TB] FAIL program_txn_count: got %0d, required %0d", txn_log.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < txn_log.size(); i++) begin
            checks++;
            if (txn_log[i].at_start !== exp_q[i] || txn_log[i].at_done !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL program_txn%0d: got start %h done %h, required %h",
                         i, txn_log[i].at_start, txn_log[i].at_done, exp_q[i]);
            end
        end
        checks++;
        if (r_err !== exp_err || r_polls !== 16'(exp_polls)) begin
            errors++;
            $display("[TB] FAIL program_resp: got err=%b polls=%0d, required err=%b polls=%0d",
                     r_err, r_polls, exp_err, exp_polls);
        end
    endtask

    task automatic test_timeout();
        int s[$];
        int acc;
        int rc;
        int polls_seen;
        logic r_err;
        logic [15:0] r_polls;
        s = '{8'h01, 8'h81, 8'h03, 8'h01, 8'h01, 8'h01};
        build_model(2'b11, 32'h0, 32'd1, s);
        script = s;
        txn_log.delete();
        send_req(2'b11, 32'h0, 32'd1, acc);
        wait_resp(r_err, r_polls, rc);
        polls_seen = 0;
        foreach (txn_log[i]) if (txn_log[i].at_start.opcode == 8'h05) polls_seen++;
        checks++;
        if (polls_seen !== exp_polls) begin
            errors++;
            $display("[TB] FAIL timeout_rdsr_count: got %0d, required %0d", polls_seen, exp_polls);
        end
        for (int i = 0; i < exp_q.size() && i < txn_log.size(); i++) begin
            checks++;
            if (txn_log[i].at_start !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL timeout_txn%0d: got %h, required %h", i, txn_log[i].at_start, exp_q[i]);
            end
        end
        checks++;
        if (r_err !== exp_err || r_polls !== 16'(exp_polls)) begin
            errors++;
            $display("[TB] FAIL timeout_resp: got err=%b polls=%0d, required err=%b polls=%0d",
                     r_err, r_polls, exp_err, exp_polls);
        end
        script.delete();
    endtask

    task automatic test_no_rx_and_busy();
        int s[$];
        int acc;
        int rc;
        int starts_before;
        int resp_before;
        logic r_err;
        logic [15:0] r_polls;
        s = '{-1, 8'h00};
        build_model(2'b10, 32'h00AB_CDEF, 32'd9, s);
        script = s;
        txn_log.delete();
        repeat (2) @(negedge clk);
        starts_before = start_count;
        resp_before   = resp_count;
        send_req(2'b10, 32'h00AB_CDEF, 32'd9, acc);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b00;
        repeat (3) begin
            checks++;
            if (bus.req_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL busy_ready: got %b, required 0", bus.req_ready);
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        wait_resp(r_err, r_polls, rc);
        repeat (10) @(negedge clk);
        checks++;
        if (resp_count - resp_before !== 1 || start_count - starts_before !== exp_q.size()) begin
            errors++;
            $display("[TB] FAIL busy_reject: got %0d resps %0d starts, required 1 resp %0d starts",
                     resp_count - resp_before, start_count - starts_before, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < txn_log.size(); i++) begin
            checks++;
            if (txn_log[i].at_start !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL norx_txn%0d: got %h, required %h", i, txn_log[i].at_start, exp_q[i]);
            end
        end
        checks++;
        if (r_err !== exp_err || r_polls !== 16'(exp_polls)) begin
            errors++;
            $display("[TB] FAIL norx_resp: got err=%b polls=%0d, required err=%b polls=%0d",
                     r_err, r_polls, exp_err, exp_polls);
        end
    endtask

    task automatic test_timing();
        int s[$];
        int acc;
        int rc;
        int got[5];
        int req[5];
        logic r_err;
        logic [15:0] r_polls;
        s = '{8'hF1, 8'h00};
        script = s;
        txn_log.delete();
        send_req(2'b00, 32'h0000_1000, 32'd16, acc);
        wait_resp(r_err, r_polls, rc);
        checks++;
        if (txn_log.size() !== 4) begin
            errors++;
            $display("[TB] FAIL timing_txn_count: got %0d, required 4", txn_log.size());
        end else begin
            got[0] = txn_log[0].start - acc;
            got[1] = txn_log[1].start - txn_log[0].done;
            got[2] = txn_log[2].start - txn_log[1].done;
            got[3] = txn_log[3].start - txn_log[2].done;
            got[4] = rc - txn_log[3].done;
            req = '{1, 1, 1 + int'(TB_POLL_GAP), 2 + int'(TB_POLL_GAP), 2};
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got[i] !== req[i]) begin
                    errors++;
                    $display("[TB] FAIL timing_gap%0d: got %0d cycles, required %0d", i, got[i], req[i]);
                end
            end
        end
        checks++;
        if (bus.req_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timing_ready_in_resp: got %b, required 0", bus.req_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timing_ready_after: ready=%b resp_valid=%b, required 1 and 0",
                     bus.req_ready, bus.resp_valid);
        end
    endtask

    task automatic test_back_to_back();
        int s[$];
        int acc;
        int rc;
        int v;
        logic r_err;
        logic [15:0] r_polls;
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] len;
        for (int n = 0; n < 8; n++) begin
            op   = 2'($urandom_range(0, 3));
            addr = $urandom();
            len  = $urandom_range(0, 4096);
            s.delete();
            repeat ($urandom_range(1, 5)) begin
                if ($urandom_range(0, 5) == 0) v = -1;
                else v = int'($urandom_range(0, 255));
                s.push_back(v);
            end
            build_model(op, addr, len, s);
            script = s;
            txn_log.delete();
            send_req(op, addr, len, acc);
            wait_resp(r_err, r_polls, rc);
            checks++;
            if (txn_log.size() !== exp_q.size()) begin
                errors++;
                $display("[TB] FAIL b2b%0d_txn_count: got %0d, required %0d", n, txn_log.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < txn_log.size(); i++) begin
                checks++;
                if (txn_log[i].at_start !== exp_q[i] || txn_log[i].at_done !== exp_q[i]) begin
                    errors++;
                    $display("[TB] FAIL b2b%0d_txn%0d: got start %h done %h, required %h",
                             n, i, txn_log[i].at_start, txn_log[i].at_done, exp_q[i]);
                end
            end
            checks++;
            if (r_err !== exp_err || r_polls !== 16'(exp_polls)) begin
                errors++;
                $display("[TB] FAIL b2b%0d_resp: got err=%b polls=%0d, required err=%b polls=%0d",
                         n, r_err, r_polls, exp_err, exp_polls);
            end
        end
        script.delete();
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_addr  = 32'd0;
        bus.req_len   = 32'd0;
        test_reset();
        test_sector_erase();
        test_program();
        test_timeout();
        test_no_rx_and_busy();
        test_timing();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/qspi_flash_sequencer.md
# qspi_flash_sequencer

Multi-transaction command sequencer that sits above `qspi_fsm` and drives its start/config ports. It turns one high-level flash request (page program, sector erase, chip erase, write-status) into the required chain: WREN (0x06), the operation itself, then repeated RDSR (0x05) polls until the status WIP bit clears or a poll limit expires. It is the only master of `qspi_fsm` while busy and reports one response per accepted request.

## Interface
- `POLL_LIMIT`, 16'd1000: maximum RDSR polls before timeout error.
- `POLL_GAP`, 8'd4: idle clk cycles between consecutive RDSR transactions.
- `WIP_BIT`, 0: status-register bit index of write-in-progress.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE.
- `req_op` in 2: 00 PROGRAM 0x02, 01 SECTOR_ERASE 0x20, 10 CHIP_ERASE 0xC7, 11 WRSR 0x01.
- `req_addr` in 32: flash address (PROGRAM/SECTOR_ERASE).
- `req_len` in 32: data bytes for PROGRAM/WRSR; ignored for erases.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_err` out 1: valid with `resp_valid`; 1 = poll timeout.
- `resp_polls` out 16: RDSR count used, valid with `resp_valid`.
- `busy` out 1: high whenever state != IDLE.
- `fsm_start` out 1: one-cycle start pulse to `qspi_fsm`.
- `fsm_done` in 1: `qspi_fsm` completion.
- `fsm_cmd_opcode` out 8, `fsm_addr` out 32, `fsm_addr_bytes_sel` out 2, `fsm_len_bytes` out 32, `fsm_dir` out 1 (1 = read), `fsm_dummy_cycles` out 4 (always 0).
- `fsm_rx_data` in 32, `fsm_rx_wen` in 1: RX write from `qspi_fsm`; status byte is `fsm_rx_data[7:0]`.

## Operation
- States: IDLE, WREN_GO, WREN_WAIT, OP_GO, OP_WAIT, GAP, POLL_GO, POLL_WAIT, CHECK, RESP.
- IDLE: on `req_valid && req_ready` latch op/addr/len, clear poll counter -> WREN_GO.
- *_GO states: `fsm_start`=1 for exactly that cycle, config outputs set for that transaction; next cycle -> matching *_WAIT.
- WREN: opcode 0x06, `fsm_addr_bytes_sel`=0, len 0, dir 0.
- OP: opcode per `req_op`; PROGRAM/SECTOR_ERASE use 3-byte address (`fsm_addr_bytes_sel`=2'b01), CHIP_ERASE/WRSR none; PROGRAM/WRSR len = `req_len`, erases len 0; dir 0.
- POLL: opcode 0x05, no address, len 1, dir 1. In POLL_WAIT each `fsm_rx_wen` captures `fsm_rx_data[7:0]`; capture register preset to 8'hFF at POLL_GO, so a poll with no RX write reads as busy.
- *_WAIT: hold all config outputs stable; on first cycle `fsm_done`=1 advance: WREN_WAIT->OP_GO, OP_WAIT->GAP, POLL_WAIT->CHECK.
- GAP: count `POLL_GAP` cycles -> POLL_GO; poll counter increments at POLL_GO (saturating at 16'hFFFF).
- CHECK: WIP=0 -> RESP err 0; WIP=1 and count == `POLL_LIMIT` -> RESP err 1; else -> GAP.
- RESP: `resp_valid`=1 one cycle, `resp_err`/`resp_polls` valid -> IDLE.
- `fsm_done` seen outside a *_WAIT state is ignored.
- `req_valid` while busy is not accepted; requester holds it.

## Timing
- Reset (and whenever rst sampled high): state IDLE; `req_ready`=1 after reset is released; `fsm_start`, `resp_valid`, `resp_err`, `busy`=0; `resp_polls`, all `fsm_*` config outputs=0. Reset mid-sequence abandons it with no response; `rst` must also reset `qspi_fsm`.
- Accept at cycle N -> `fsm_start` (WREN) at N+1.
- `fsm_done` seen at cycle M -> next `fsm_start` at M+1 (WREN->OP) or M+1+POLL_GAP (OP->first poll, and CHECK-busy->next poll measured from CHECK+1).
- POLL_WAIT done at M -> CHECK at M+1 -> RESP at M+2 -> `req_ready` at M+3.
- POLL_GAP=0: GAP lasts one cycle.
- Config outputs change only in *_GO cycles.

## Test plan
- Reset: hold rst 3 cycles mid-OP_WAIT -> state IDLE, `fsm_start`=0, `req_ready`=1, no `resp_valid`.
- SECTOR_ERASE addr 0x012000, model returns status 0x03,0x03,0x00 -> starts with opcodes 06,20,05,05,05; addr 0x012000 with sel 01 on erase; `resp_valid` err 0, `resp_polls`=3.
- PROGRAM len 256 -> OP transaction opcode 0x02, `fsm_len_bytes`=256, dir 0; first status 0x00 -> `resp_polls`=1.
- Timeout: POLL_LIMIT=4, status always 0x01 -> exactly 4 RDSR starts, `resp_err`=1, `resp_polls`=4.
- No RX write during a poll -> treated as busy, another poll issued; `req_valid` pulsed while busy -> not accepted, `req_ready`=0.
- Timing: measure accept->WREN start = 1 cycle, done->next start = 1 cycle (WREN->OP), POLL_GAP=4 -> done->poll start = 5 cycles.
